// File: rtl/seg_ctrl.sv
// seg_ctrl: eight-digit seven-segment controller with a two-requester round-robin
// write port into the digit buffer and an optional rotating (scrolling) view.
module seg_ctrl #(
  parameter int TICK_NUM = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [2:0] req0_idx,
  input  logic [5:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_idx,
  input  logic [5:0] req1_data,
  output logic       req1_ready,
  input  logic       scroll_en,
  output logic [7:0] o_seg1,
  output logic [7:0] o_seg2,
  output logic [7:0] o_seg3,
  output logic [7:0] o_seg4,
  output logic [7:0] o_seg5,
  output logic [7:0] o_seg6,
  output logic [7:0] o_seg7,
  output logic [7:0] o_seg8
);
  typedef enum logic {STATIC, SCROLL} state_t;
  state_t      state, state_nxt;
  logic        ptr;
  logic [5:0]  buffer [8];
  logic [31:0] tick, tick_nxt;
  logic [2:0]  offset, offset_nxt;
  logic [7:0]  seg [8];
  logic        wrap;

  function automatic logic [7:0] decode(input logic [5:0] e);
    logic [7:0] p;
    case (e[3:0])
      4'h0: p = 8'hFC;
      4'h1: p = 8'h60;
      4'h2: p = 8'hDA;
      4'h3: p = 8'hF2;
      4'h4: p = 8'h66;
      4'h5: p = 8'hB6;
      4'h6: p = 8'hBE;
      4'h7: p = 8'hE0;
      4'h8: p = 8'hFE;
      4'h9: p = 8'hF6;
      4'hA: p = 8'hEE;
      4'hB: p = 8'h3E;
      4'hC: p = 8'h9C;
      4'hD: p = 8'h7A;
      4'hE: p = 8'h9E;
      default: p = 8'h8E;
    endcase
    return e[5] ? 8'h00 : {p[7:1], e[4]};
  endfunction

  // ptr=0 favours requester 0 on contention; a lone requester always wins
  assign req0_ready = req0_valid & (~req1_valid | ~ptr);
  assign req1_ready = req1_valid & (~req0_valid | ptr);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (req0_ready) ptr <= 1'b1;
    else if (req1_ready) ptr <= 1'b0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) buffer[i] <= 6'h20;
    end else begin
      if (req0_ready) buffer[req0_idx] <= req0_data;
      if (req1_ready) buffer[req1_idx] <= req1_data;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= STATIC;
      tick   <= '0;
      offset <= '0;
    end else begin
      state  <= state_nxt;
      tick   <= tick_nxt;
      offset <= offset_nxt;
    end

  assign wrap = tick == 32'(TICK_NUM);

  always_comb begin
    state_nxt  = scroll_en ? SCROLL : STATIC;
    tick_nxt   = '0;
    offset_nxt = '0;
    if (state == SCROLL && scroll_en) begin
      tick_nxt   = wrap ? '0 : tick + 32'd1;
      offset_nxt = wrap ? offset + 3'd1 : offset;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) seg[k] <= 8'hFF;
    end else begin
      for (int k = 0; k < 8; k++) seg[k] <= ~decode(buffer[3'(k) + offset]);
    end

  assign o_seg1 = seg[0];
  assign o_seg2 = seg[1];
  assign o_seg3 = seg[2];
  assign o_seg4 = seg[3];
  assign o_seg5 = seg[4];
  assign o_seg6 = seg[5];
  assign o_seg7 = seg[6];
  assign o_seg8 = seg[7];
endmodule

// File: tb/tb_seg_ctrl.sv
// tb_seg_ctrl: directed and randomized checks of seg_ctrl against a behavioural model
// (buffer array, turn flag, scroll time -> offset by division).
module tb_seg_ctrl;
  localparam int T = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic v0 = 0, v1 = 0, scroll_en = 0;
  logic [2:0] idx0 = 0, idx1 = 0;
  logic [5:0] d0 = 0, d1 = 0;
  logic r0, r1;
  logic [7:0] s1, s2, s3, s4, s5, s6, s7, s8;
  logic [7:0] seg [8];
  int checks = 0, errors = 0;

  logic [5:0] mb [8];
  logic [7:0] exp_seg [8];
  int turn, scnt, moff;
  bit msc;

  seg_ctrl #(.TICK_NUM(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_idx(idx0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_idx(idx1), .req1_data(d1), .req1_ready(r1),
    .scroll_en(scroll_en),
    .o_seg1(s1), .o_seg2(s2), .o_seg3(s3), .o_seg4(s4),
    .o_seg5(s5), .o_seg6(s6), .o_seg7(s7), .o_seg8(s8)
  );

  always #5 clk = ~clk;

  always_comb begin
    seg[0] = s1; seg[1] = s2; seg[2] = s3; seg[3] = s4;
    seg[4] = s5; seg[5] = s6; seg[6] = s7; seg[7] = s8;
  end

  function automatic logic [7:0] pat(input logic [5:0] e);
    logic [7:0] p;
    case (e[3:0])
      0: p = 8'hFC; 1: p = 8'h60; 2: p = 8'hDA; 3: p = 8'hF2;
      4: p = 8'h66; 5: p = 8'hB6; 6: p = 8'hBE; 7: p = 8'hE0;
      8: p = 8'hFE; 9: p = 8'hF6; 10: p = 8'hEE; 11: p = 8'h3E;
      12: p = 8'h9C; 13: p = 8'h7A; 14: p = 8'h9E; default: p = 8'h8E;
    endcase
    if (e[5]) return 8'h00;
    p[0] = e[4];
    return p;
  endfunction

  function automatic bit exp_g0();
    return v0 && (!v1 || turn == 0);
  endfunction

  function automatic bit exp_g1();
    return v1 && !(v0 && (!v1 || turn == 0));
  endfunction

  task automatic mreset();
    for (int i = 0; i < 8; i++) begin
      mb[i] = 6'h20;
      exp_seg[i] = 8'hFF;
    end
    turn = 0; msc = 0; scnt = 0; moff = 0;
  endtask

  // one clock edge: capture pre-edge inputs, advance the model, settle 1 time unit
  task automatic tick();
    bit g0, g1, se;
    logic [2:0] i0, i1;
    logic [5:0] x0, x1;
    g0 = exp_g0(); g1 = exp_g1(); se = scroll_en;
    i0 = idx0; i1 = idx1; x0 = d0; x1 = d1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) exp_seg[k] = ~pat(mb[(k + moff) % 8]);
    if (g0) begin mb[i0] = x0; turn = 1; end
    if (g1) begin mb[i1] = x1; turn = 0; end
    if (!msc) begin
      if (se) begin msc = 1; scnt = 0; end
      moff = 0;
    end else if (!se) begin
      msc = 0; moff = 0;
    end else begin
      scnt++;
      moff = (scnt / (T + 1)) % 8;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    mreset();
    #1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (seg[k] !== 8'hFF) begin
        errors++;
        $display("FAIL reset_seg%0d got %h want ff", k + 1, seg[k]);
      end
    end
    checks++;
    if ({r0, r1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got %b want 00", {r0, r1});
    end
  endtask

  task automatic test_single_write();
    v0 = 1; idx0 = 2; d0 = 6'h03;
    #1 checks++;
    if ({r0, r1} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready got %b want 10", {r0, r1});
    end
    tick();
    v0 = 0;
    tick();
    checks++;
    if (seg[2] !== 8'h0D) begin
      errors++;
      $display("FAIL single_seg3 got %h want 0d", seg[2]);
    end
    v1 = 1; idx1 = 5; d1 = 6'h20;
    #1 checks++;
    if ({r0, r1} !== 2'b01) begin
      errors++;
      $display("FAIL lone_req1_ready got %b want 01", {r0, r1});
    end
    tick();
    v1 = 0;
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] want [3];
    want[0] = 2'b10; want[1] = 2'b01; want[2] = 2'b10;
    v0 = 1; idx0 = 0; d0 = 6'h01;
    v1 = 1; idx1 = 0; d1 = 6'h02;
    for (int c = 0; c < 3; c++) begin
      #1 checks++;
      if ({r0, r1} !== want[c] || {r0, r1} !== {exp_g0(), exp_g1()}) begin
        errors++;
        $display("FAIL contention_grant%0d got %b want %b", c, {r0, r1}, want[c]);
      end
      tick();
      if (c == 2) begin
        checks++;
        if (seg[0] !== 8'h25) begin
          errors++;
          $display("FAIL contention_seg1 got %h want 25", seg[0]);
        end
      end
    end
    v0 = 0; v1 = 0;
    tick();
    checks++;
    if (seg[0] !== 8'h9F) begin
      errors++;
      $display("FAIL contention_last_writer got %h want 9f", seg[0]);
    end
  endtask

  task automatic test_scroll();
    for (int i = 0; i < 8; i++) begin
      v0 = 1; idx0 = 3'(i); d0 = 6'(i);
      tick();
    end
    v0 = 0;
    tick();
    checks++;
    if (seg[0] !== 8'h03) begin
      errors++;
      $display("FAIL scroll_static_seg1 got %h want 03", seg[0]);
    end
    scroll_en = 1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (seg[k] !== exp_seg[k]) begin
          errors++;
          $display("FAIL scroll_seg%0d cyc%0d got %h want %h", k + 1, n, seg[k], exp_seg[k]);
        end
      end
      if (n == 6 || n == 34) begin
        checks++;
        if (seg[0] !== (n == 6 ? 8'h9F : 8'h03)) begin
          errors++;
          $display("FAIL scroll_step_seg1 cyc%0d got %h want %h", n, seg[0], (n == 6 ? 8'h9F : 8'h03));
        end
      end
    end
    scroll_en = 0;
    tick(); tick();
    checks++;
    if (seg[0] !== 8'h03) begin
      errors++;
      $display("FAIL scroll_stop_seg1 got %h want 03", seg[0]);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    scroll_en = 1;
    while (moff != 5 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (moff != 5) begin
      errors++;
      $display("FAIL async_wait_offset got %0d want 5", moff);
    end
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (seg[k] !== 8'hFF) begin
        errors++;
        $display("FAIL async_seg%0d got %h want ff", k + 1, seg[k]);
      end
    end
    scroll_en = 0;
    #1 rst_n = 1;
    mreset();
    v0 = 1; idx0 = 0; d0 = 6'h0A;
    tick();
    v0 = 0;
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (seg[k] !== exp_seg[k] || seg[k] !== (k == 0 ? 8'h11 : 8'hFF)) begin
        errors++;
        $display("FAIL async_after_seg%0d got %h want %h", k + 1, seg[k], exp_seg[k]);
      end
    end
  endtask

  task automatic test_blank_dp();
    v0 = 1; idx0 = 7; d0 = 6'h3F;
    tick();
    idx0 = 6; d0 = 6'h13;
    tick();
    v0 = 0;
    tick();
    checks++;
    if (seg[7] !== 8'hFF) begin
      errors++;
      $display("FAIL blank_dp_seg8 got %h want ff", seg[7]);
    end
    checks++;
    if (seg[6] !== 8'h0C) begin
      errors++;
      $display("FAIL dp_seg7 got %h want 0c", seg[6]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      idx0 = 3'($urandom); idx1 = 3'($urandom);
      d0 = 6'($urandom); d1 = 6'($urandom);
      if ($urandom_range(0, 19) == 0) scroll_en = ~scroll_en;
      #1 checks++;
      if ({r0, r1} !== {exp_g0(), exp_g1()}) begin
        errors++;
        $display("FAIL rand_ready cyc%0d got %b want %b", n, {r0, r1}, {exp_g0(), exp_g1()});
      end
      tick();
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (seg[k] !== exp_seg[k]) begin
          errors++;
          $display("FAIL rand_seg%0d cyc%0d got %h want %h", k + 1, n, seg[k], exp_seg[k]);
        end
      end
    end
    v0 = 0; v1 = 0; scroll_en = 0;
  endtask

  initial begin
    mreset();
    test_reset();
    test_single_write();
    test_contention();
    test_scroll();
    test_async_reset();
    test_blank_dp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
